// File: rtl/decode_stage_if.sv
// Handshake and result bundle between fetch, the decode stage, execute and writeback.
// The decode stage is the slave; the fetch/execute/writeback side is the master.
interface decode_stage_if #(
    parameter int ISA_WIDTH      = 16,
    parameter int REG_ADDR_WIDTH = 4
);
    localparam int NREG       = 1 << REG_ADDR_WIDTH;
    localparam int IMM_WIDTH0 = ISA_WIDTH - 3 - 2 * REG_ADDR_WIDTH;
    localparam int IMM_WIDTH1 = ISA_WIDTH - 3 - REG_ADDR_WIDTH;

    logic                      in_valid;
    logic                      in_ready;
    logic [ISA_WIDTH-1:0]      in_inst;
    logic                      out_valid;
    logic                      out_ready;
    logic [2:0]                out_opcode;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic [REG_ADDR_WIDTH-1:0] out_rs1;
    logic [REG_ADDR_WIDTH-1:0] out_rs2;
    logic [IMM_WIDTH0-1:0]     out_imm0;
    logic [IMM_WIDTH1-1:0]     out_imm1;
    logic                      out_funct;
    logic                      out_we;
    logic                      out_illegal;
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      flush;
    logic [NREG-1:0]           busy;

    modport master (
        output in_valid, in_inst, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm0, out_imm1, out_funct, out_we, out_illegal, busy
    );

    modport slave (
        input  in_valid, in_inst, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm0, out_imm1, out_funct, out_we, out_illegal, busy
    );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage for the LOAD/STORE/MOV/MAC ISA with a per-register
// busy scoreboard that stalls issue on RAW/WAW hazards until writeback.
module decode_stage #(
    parameter int ISA_WIDTH      = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam int R          = REG_ADDR_WIDTH;
    localparam int NREG       = 1 << R;
    localparam int IMM_WIDTH0 = ISA_WIDTH - 3 - 2 * R;
    localparam int IMM_WIDTH1 = ISA_WIDTH - 3 - R;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_MOV   = 3'b010;
    localparam logic [2:0] OP_MAC   = 3'b100;

    logic [2:0]            w_opcode;
    logic [R-1:0]          w_fa, w_fb, w_fc;
    logic [R-1:0]          w_rd, w_rs1, w_rs2;
    logic [IMM_WIDTH0-1:0] w_imm0;
    logic [IMM_WIDTH1-1:0] w_imm1;
    logic                  w_funct, w_we, w_illegal;
    logic [NREG-1:0]       w_need, w_wb_mask, w_busy_nxt;
    logic                  w_hazard, w_in_ready, w_accept;

    logic                  r_out_valid;
    logic [2:0]            r_opcode;
    logic [R-1:0]          r_rd, r_rs1, r_rs2;
    logic [IMM_WIDTH0-1:0] r_imm0;
    logic [IMM_WIDTH1-1:0] r_imm1;
    logic                  r_funct, r_we, r_illegal;
    logic [NREG-1:0]       r_busy;

    assign w_opcode = bus.in_inst[ISA_WIDTH-1 -: 3];
    assign w_fa     = bus.in_inst[ISA_WIDTH-4 -: R];
    assign w_fb     = bus.in_inst[ISA_WIDTH-4-R -: R];
    assign w_fc     = bus.in_inst[ISA_WIDTH-4-2*R -: R];

    // w_need collects every register the instruction reads plus its rd when it writes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        w_rd      = '0;
        w_rs1     = '0;
        w_rs2     = '0;
        w_imm0    = '0;
        w_imm1    = '0;
        w_funct   = 1'b0;
        w_we      = 1'b0;
        w_illegal = 1'b0;
        w_need    = '0;
        case (w_opcode)
            OP_LOAD: begin
                w_rd         = w_fa;
                w_rs1        = w_fb;
                w_imm0       = bus.in_inst[IMM_WIDTH0-1:0];
                w_we         = 1'b1;
                w_need[w_fb] = 1'b1;
                w_need[w_fa] = 1'b1;
            end
            OP_STORE: begin
                w_rs1        = w_fa;
                w_rs2        = w_fb;
                w_need[w_fa] = 1'b1;
                w_need[w_fb] = 1'b1;
            end
            OP_MOV: begin
                w_rd         = w_fa;
                w_imm1       = bus.in_inst[IMM_WIDTH1-1:0];
                w_we         = 1'b1;
                w_need[w_fa] = 1'b1;
            end
            OP_MAC: begin
                w_rd         = w_fa;
                w_we         = 1'b1;
                w_funct      = bus.in_inst[0];
                w_need[w_fa] = 1'b1;
                if (bus.in_inst[0]) begin
                    w_rs2        = w_fb;
                    w_need[w_fb] = 1'b1;
                end else begin
                    w_rs1        = w_fb;
                    w_rs2        = w_fc;
                    w_need[w_fb] = 1'b1;
                    w_need[w_fc] = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // A register released by writeback this cycle counts as free for the hazard check.
    always_comb begin
        w_wb_mask = '0;
        if (bus.wb_valid) w_wb_mask[bus.wb_rd] = 1'b1;
    end

    assign w_hazard   = |(w_need & r_busy & ~w_wb_mask);
    assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Clears (writeback, flushed entry) apply first so a same-cycle set wins.
    always_comb begin
        w_busy_nxt = r_busy & ~w_wb_mask;
        if (bus.flush && r_out_valid && r_we) w_busy_nxt[r_rd] = 1'b0;
        if (w_accept && w_we)                 w_busy_nxt[w_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm0      <= '0;
            r_imm1      <= '0;
            r_funct     <= 1'b0;
            r_we        <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_opcode    <= w_opcode;
                r_rd        <= w_rd;
                r_rs1       <= w_rs1;
                r_rs2       <= w_rs2;
                r_imm0      <= w_imm0;
                r_imm1      <= w_imm1;
                r_funct     <= w_funct;
                r_we        <= w_we;
                r_illegal   <= w_illegal;
            end else if (bus.flush || bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_opcode  = r_opcode;
    assign bus.out_rd      = r_rd;
    assign bus.out_rs1     = r_rs1;
    assign bus.out_rs2     = r_rs2;
    assign bus.out_imm0    = r_imm0;
    assign bus.out_imm1    = r_imm1;
    assign bus.out_funct   = r_funct;
    assign bus.out_we      = r_we;
    assign bus.out_illegal = r_illegal;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, scoreboard hazards, writeback
// bypass, back-pressure, flush and asynchronous reset.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    decode_stage_if #(.ISA_WIDTH(16), .REG_ADDR_WIDTH(4)) bus ();

    decode_stage #(.ISA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] op,
                             input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [4:0] i0, input logic [8:0] i1,
                             input logic f, input logic we, input logic ill);
        check({tag, ".valid"},   32'(bus.out_valid),   32'(v));
        check({tag, ".opcode"},  32'(bus.out_opcode),  32'(op));
        check({tag, ".rd"},      32'(bus.out_rd),      32'(rd));
        check({tag, ".rs1"},     32'(bus.out_rs1),     32'(rs1));
        check({tag, ".rs2"},     32'(bus.out_rs2),     32'(rs2));
        check({tag, ".imm0"},    32'(bus.out_imm0),    32'(i0));
        check({tag, ".imm1"},    32'(bus.out_imm1),    32'(i1));
        check({tag, ".funct"},   32'(bus.out_funct),   32'(f));
        check({tag, ".we"},      32'(bus.out_we),      32'(we));
        check({tag, ".illegal"}, 32'(bus.out_illegal), 32'(ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.flush     = 1'b0;
        repeat (2) tick();
        check_out("reset", 0, 3'd0, 4'd0, 4'd0, 4'd0, 5'd0, 9'd0, 0, 0, 0);
        check("reset.busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;

        // LOAD rd=3 rs1=5 imm0=7
        bus.in_valid = 1'b1;
        bus.in_inst  = 16'h06A7;
        #1 check("load.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("load", 1, 3'b000, 4'd3, 4'd5, 4'd0, 5'd7, 9'd0, 0, 1, 0);
        check("load.busy", 32'(bus.busy), 32'h0008);

        // MOV rd=2 imm1=0x1FF, back to back
        bus.in_inst = 16'h45FF;
        #1 check("mov.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("mov", 1, 3'b010, 4'd2, 4'd0, 4'd0, 5'd0, 9'h1FF, 0, 1, 0);
        check("mov.busy", 32'(bus.busy), 32'h000C);

        // Release r2, then MAC reads r2,r3 with r3 released by same-cycle writeback
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd2;
        tick();
        check("wb2.busy", 32'(bus.busy), 32'h0008);
        bus.in_valid = 1'b1;
        bus.in_inst  = 16'h8246;
        bus.wb_rd    = 4'd3;
        #1 check("mac0.bypass_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("mac0", 1, 3'b100, 4'd1, 4'd2, 4'd3, 5'd0, 9'd0, 0, 1, 0);
        check("mac0.busy", 32'(bus.busy), 32'h0002);

        // MAC f=1 rd=1 while busy[1]=1 and wb_rd=1: set wins over clear
        bus.in_inst = 16'h8281;
        bus.wb_rd   = 4'd1;
        #1 check("mac1.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("mac1", 1, 3'b100, 4'd1, 4'd0, 4'd4, 5'd0, 9'd0, 1, 1, 0);
        check("mac1.busy_set_wins", 32'(bus.busy), 32'h0002);

        // Illegal opcode 011
        bus.wb_valid = 1'b0;
        bus.in_inst  = 16'h6000;
        #1 check("ill.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("ill", 1, 3'b011, 4'd0, 4'd0, 4'd0, 5'd0, 9'd0, 0, 0, 1);
        check("ill.busy", 32'(bus.busy), 32'h0002);

        // Release r1
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd1;
        tick();
        check("wb1.busy", 32'(bus.busy), 32'h0000);
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);
        bus.wb_valid = 1'b0;

        // RAW: LOAD r3 then STORE reading r3 stalls until writeback
        bus.in_valid = 1'b1;
        bus.in_inst  = 16'h06A7;
        tick();
        check("raw.busy_set", 32'(bus.busy), 32'h0008);
        bus.in_inst = 16'h2620;
        #1 check("raw.stall", 32'(bus.in_ready), 32'd0);
        tick();
        check("raw.out_drained", 32'(bus.out_valid), 32'd0);
        check("raw.busy_held", 32'(bus.busy), 32'h0008);
        check("raw.stall2", 32'(bus.in_ready), 32'd0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd3;
        #1 check("raw.wb_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("store", 1, 3'b001, 4'd0, 4'd3, 4'd1, 5'd0, 9'd0, 0, 0, 0);
        check("store.busy", 32'(bus.busy), 32'h0000);
        bus.wb_valid = 1'b0;

        // Back-pressure: MOV r2 held three cycles, MAC r1 waits
        bus.in_inst = 16'h45FF;
        tick();
        bus.out_ready = 1'b0;
        bus.in_inst   = 16'h8281;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp.in_ready", 32'(bus.in_ready), 32'd0);
            check_out("bp.hold", 1, 3'b010, 4'd2, 4'd0, 4'd0, 5'd0, 9'h1FF, 0, 1, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1 check("bp.release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("bp.next", 1, 3'b100, 4'd1, 4'd0, 4'd4, 5'd0, 9'd0, 1, 1, 0);
        check("bp.busy", 32'(bus.busy), 32'h0006);

        // Flush a LOAD r3 entry; a hazard-free MOV r5 offered meanwhile is refused
        bus.in_inst = 16'h06A7;
        tick();
        check("fl.busy_before", 32'(bus.busy), 32'h000E);
        bus.flush   = 1'b1;
        bus.in_inst = 16'h4A00;
        #1 check("fl.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("fl.out_valid", 32'(bus.out_valid), 32'd0);
        check("fl.busy_after", 32'(bus.busy), 32'h0006);
        bus.flush = 1'b0;
        tick();
        check_out("mov5", 1, 3'b010, 4'd5, 4'd0, 4'd0, 5'd0, 9'd0, 0, 1, 0);
        check("mov5.busy", 32'(bus.busy), 32'h0026);

        // Asynchronous reset mid-cycle
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 3'd0, 4'd0, 4'd0, 4'd0, 5'd0, 9'd0, 0, 0, 0);
        check("async_rst.busy", 32'(bus.busy), 32'h0000);
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst  = 16'h06A7;
        #1 check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("post_rst.busy", 32'(bus.busy), 32'h0008);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
